// File: rtl/stream_raster_pkg.sv
// Shared types and helpers for the pixel-stream source blocks.
package stream_raster_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } raster_state_e;

  // Counter width for a range of 'value' positions (at least one bit).
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_raster_counter.sv
// Frame position counter: column wraps into row, row wraps into frame.
module raster_counter
  import stream_raster_pkg::*;
#(
  parameter int FRAME_HEIGHT = 4,
  parameter int FRAME_WIDTH  = 6,
  localparam int V_BITW = log2_ceil(FRAME_HEIGHT),
  localparam int H_BITW = log2_ceil(FRAME_WIDTH)
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              advance,
  output logic [V_BITW-1:0] vcnt,
  output logic [H_BITW-1:0] hcnt,
  output logic              last_col,
  output logic              last_frame
);

  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(FRAME_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(FRAME_WIDTH - 1);

  assign last_col   = (hcnt == H_LAST);
  assign last_frame = last_col && (vcnt == V_LAST);

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      vcnt <= '0;
      hcnt <= '0;
    end else if (advance) begin
      if (last_col) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_raster.sv
// Raster stream source: turns a raster-order pixel handshake into a
// per-cycle coordinate stream with sync positions and a downstream enable.
module stream_raster
  import stream_raster_pkg::*;
#(
  parameter int BIT_WIDTH    = 8,
  parameter int IMAGE_HEIGHT = 3,
  parameter int IMAGE_WIDTH  = 4,
  parameter int FRAME_HEIGHT = 4,
  parameter int FRAME_WIDTH  = 6,
  localparam int V_BITW = log2_ceil(FRAME_HEIGHT),
  localparam int H_BITW = log2_ceil(FRAME_WIDTH)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 run,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_pixel,
  input  logic                 out_stall,
  output logic                 out_enable,
  output logic [BIT_WIDTH-1:0] out_pixel,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt,
  output logic                 out_underrun
);

  localparam logic [V_BITW-1:0] V_IMG = V_BITW'(IMAGE_HEIGHT);
  localparam logic [H_BITW-1:0] H_IMG = H_BITW'(IMAGE_WIDTH);

  raster_state_e        state;
  logic                 hold_full;
  logic [BIT_WIDTH-1:0] hold_data;
  logic [V_BITW-1:0]    vcnt;
  logic [H_BITW-1:0]    hcnt;
  logic                 last_col;
  logic                 last_frame;
  logic                 active;
  logic                 adv;
  logic                 consume;
  logic                 accept;
  logic                 frame_done;

  raster_counter #(
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .FRAME_WIDTH (FRAME_WIDTH)
  ) u_counter (
    .clock     (clock),
    .n_rst     (n_rst),
    .advance   (adv),
    .vcnt      (vcnt),
    .hcnt      (hcnt),
    .last_col  (last_col),
    .last_frame(last_frame)
  );

  assign active     = (vcnt < V_IMG) && (hcnt < H_IMG);
  assign adv        = (state == ST_RUN) && !out_stall && (!active || hold_full);
  assign consume    = adv && active;
  assign frame_done = last_col && last_frame;

  // Handshake: a pixel transfers on a rising edge where in_valid && in_ready;
  // in_ready frees up in the same cycle the held pixel is consumed.
  assign in_ready = !hold_full || consume;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (run) state <= ST_RUN;
        ST_RUN:  if (adv && frame_done && !run) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= in_pixel;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Coordinates and pixel freeze while enable is low.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      out_enable   <= 1'b0;
      out_pixel    <= '0;
      out_vcnt     <= '0;
      out_hcnt     <= '0;
      out_underrun <= 1'b0;
    end else begin
      out_enable   <= adv;
      out_underrun <= (state == ST_RUN) && !out_stall && active && !hold_full;
      if (adv) begin
        out_pixel <= active ? hold_data : '0;
        out_vcnt  <= vcnt;
        out_hcnt  <= hcnt;
      end
    end
  end

endmodule

// File: tb/tb_stream_raster.sv
// Bench for stream_raster: beat-ordered scoreboard plus directed timing checks.
module tb_stream_raster;

  localparam int IH = 3;
  localparam int IW = 4;
  localparam int FH = 4;
  localparam int FW = 6;
  localparam int FW_W = 8;

  int tests = 0;
  int fails = 0;

  // clock/reset
  logic clock = 1'b0;
  logic n_rst;
  always #5 clock = ~clock;

  // main DUT (frame 4x6)
  logic       run, in_valid, in_ready, out_stall, out_enable, out_underrun;
  logic [7:0] in_pixel, out_pixel;
  logic [1:0] out_vcnt;
  logic [2:0] out_hcnt;

  // wrap DUT (frame 4x8)
  logic       run_w, in_valid_w, in_ready_w, out_stall_w, out_enable_w, out_underrun_w;
  logic [7:0] in_pixel_w, out_pixel_w;
  logic [1:0] out_vcnt_w;
  logic [2:0] out_hcnt_w;

  stream_raster #(.BIT_WIDTH(8), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
                  .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW)) dut (
    .clock(clock), .n_rst(n_rst), .run(run), .in_valid(in_valid),
    .in_ready(in_ready), .in_pixel(in_pixel), .out_stall(out_stall),
    .out_enable(out_enable), .out_pixel(out_pixel), .out_vcnt(out_vcnt),
    .out_hcnt(out_hcnt), .out_underrun(out_underrun)
  );

  stream_raster #(.BIT_WIDTH(8), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
                  .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW_W)) dut_w (
    .clock(clock), .n_rst(n_rst), .run(run_w), .in_valid(in_valid_w),
    .in_ready(in_ready_w), .in_pixel(in_pixel_w), .out_stall(out_stall_w),
    .out_enable(out_enable_w), .out_pixel(out_pixel_w), .out_vcnt(out_vcnt_w),
    .out_hcnt(out_hcnt_w), .out_underrun(out_underrun_w)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // scoreboard: expected pixels in acceptance order, positions by beat index
  logic [7:0] exp_q[$];
  int         beat_idx;
  logic [7:0] beat_pix [0:FH-1][0:FW-1];

  always @(negedge clock) begin
    int pos, ev, eh;
    logic [7:0] e;
    if (!n_rst) begin
      exp_q.delete();
      beat_idx = 0;
    end else begin
      if (out_enable) begin
        pos = beat_idx % (FH * FW);
        ev  = pos / FW;
        eh  = pos % FW;
        check("beat_vcnt", 32'(out_vcnt), 32'(ev));
        check("beat_hcnt", 32'(out_hcnt), 32'(eh));
        check("beat_in_range", 32'(out_vcnt < FH && out_hcnt < FW), 32'd1);
        if (ev < IH && eh < IW) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL beat_pixel_missing: pixel %0d at (%0d,%0d) with nothing accepted", out_pixel, ev, eh);
          end else begin
            e = exp_q.pop_front();
            tests--;
            check("beat_pixel", 32'(out_pixel), 32'(e));
          end
        end else begin
          check("sync_pixel", 32'(out_pixel), 32'd0);
        end
        beat_pix[ev][eh] = out_pixel;
        beat_idx++;
      end
      if (in_valid && in_ready) exp_q.push_back(in_pixel);
    end
  end

  logic [7:0] wq[$];
  int         widx;

  always @(negedge clock) begin
    int pos, ev, eh;
    logic [7:0] e;
    if (!n_rst) begin
      wq.delete();
      widx = 0;
    end else begin
      if (out_enable_w) begin
        pos = widx % (FH * FW_W);
        ev  = pos / FW_W;
        eh  = pos % FW_W;
        check("w_vcnt", 32'(out_vcnt_w), 32'(ev));
        check("w_hcnt", 32'(out_hcnt_w), 32'(eh));
        if (ev < IH && eh < IW) begin
          e = (wq.size() > 0) ? wq.pop_front() : 8'hxx;
          check("w_pixel", 32'(out_pixel_w), 32'(e));
        end else begin
          check("w_sync_pixel", 32'(out_pixel_w), 32'd0);
        end
        widx++;
      end
      if (in_valid_w && in_ready_w) wq.push_back(in_pixel_w);
    end
  end

  initial begin
    run_w = 1'b1;
    in_valid_w = 1'b1;
    in_pixel_w = '0;
    out_stall_w = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      in_pixel_w  = 8'($urandom_range(0, 255));
      out_stall_w = ($urandom_range(0, 4) == 0);
    end
  end

  // driver: inputs set after posedge, outputs snapshotted at negedge
  logic [7:0] pix_val;
  logic       s_en, s_ur, s_rdy;
  logic [1:0] s_v;
  logic [2:0] s_h;
  logic [7:0] s_pix;

  task automatic tick(input logic v, input logic s);
    in_valid  = v;
    out_stall = s;
    in_pixel  = pix_val;
    @(negedge clock);
    s_en = out_enable; s_v = out_vcnt; s_h = out_hcnt;
    s_pix = out_pixel; s_ur = out_underrun; s_rdy = in_ready;
    if (in_valid && in_ready) pix_val = pix_val + 8'd1;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    n_rst = 1'b0; run = 1'b0; in_valid = 1'b0; out_stall = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_rst = 1'b1;
    pix_val = 8'd1;
  endtask

  initial begin
    bit found;
    int cnt, gap, urun;
    n_rst = 1'b0; run = 1'b0; in_valid = 1'b0; out_stall = 1'b0;
    in_pixel = '0; pix_val = 8'd1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_enable", 32'(out_enable), 32'd0);
    check("rst_pixel", 32'(out_pixel), 32'd0);
    check("rst_vcnt", 32'(out_vcnt), 32'd0);
    check("rst_hcnt", 32'(out_hcnt), 32'd0);
    check("rst_underrun", 32'(out_underrun), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    n_rst = 1'b1;

    // continuous frame, pixels 1..12
    run = 1'b1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1, 0);
      if (s_en) begin found = 1; break; end
    end
    check("s1_first_beat_seen", 32'(found), 32'd1);
    check("s1_first_v", 32'(s_v), 32'd0);
    check("s1_first_h", 32'(s_h), 32'd0);
    check("s1_first_pix", 32'(s_pix), 32'd1);
    cnt = 1;
    for (int k = 0; k < 23; k++) begin
      tick(1, 0);
      if (s_en) cnt++;
    end
    check("s1_consecutive_beats", 32'(cnt), 32'd24);
    tick(1, 0);
    check("s1_next_frame_en", 32'(s_en), 32'd1);
    check("s1_next_frame_v", 32'(s_v), 32'd0);
    check("s1_next_frame_h", 32'(s_h), 32'd0);
    check("s1_next_frame_pix", 32'(s_pix), 32'd13);
    check("s1_pix_0_3", 32'(beat_pix[0][3]), 32'd4);
    check("s1_pix_2_3", 32'(beat_pix[2][3]), 32'd12);
    check("s1_pix_0_4", 32'(beat_pix[0][4]), 32'd0);
    check("s1_pix_3_5", 32'(beat_pix[3][5]), 32'd0);

    // input gap before pixel 6
    reset_dut();
    run = 1'b1;
    for (int k = 0; k < 20 && pix_val <= 8'd5; k++) tick(1, 0);
    found = 0;
    for (int k = 0; k < 30; k++) begin
      tick(0, 0);
      if (s_en && s_v == 2'd1 && s_h == 3'd0) begin found = 1; break; end
    end
    check("s2_beat_1_0_seen", 32'(found), 32'd1);
    gap = 0; urun = 0; found = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(k >= 3, 0);
      if (s_ur) urun++;
      if (s_en) begin found = 1; break; end
      gap++;
    end
    check("s2_resume_seen", 32'(found), 32'd1);
    check("s2_enable_gap", 32'(gap), 32'd4);
    check("s2_underrun_cycles", 32'(urun), 32'd4);
    check("s2_resume_v", 32'(s_v), 32'd1);
    check("s2_resume_h", 32'(s_h), 32'd1);
    check("s2_resume_pix", 32'(s_pix), 32'd6);
    repeat (30) tick(1, 0);

    // stall at (0,4) with hold full
    reset_dut();
    run = 1'b1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1, 0);
      if (s_en && s_v == 2'd0 && s_h == 3'd2) begin found = 1; break; end
    end
    check("s3_pre_seen", 32'(found), 32'd1);
    tick(1, 1);
    check("s3_a_en", 32'(s_en), 32'd1);
    check("s3_a_h", 32'(s_h), 32'd3);
    check("s3_a_ready", 32'(s_rdy), 32'd0);
    tick(1, 1);
    check("s3_b_en", 32'(s_en), 32'd0);
    check("s3_b_h", 32'(s_h), 32'd3);
    check("s3_b_pix", 32'(s_pix), 32'd4);
    check("s3_b_ready", 32'(s_rdy), 32'd0);
    tick(1, 0);
    check("s3_c_en", 32'(s_en), 32'd0);
    check("s3_c_h", 32'(s_h), 32'd3);
    check("s3_c_pix", 32'(s_pix), 32'd4);
    tick(1, 0);
    check("s3_d_en", 32'(s_en), 32'd1);
    check("s3_d_h", 32'(s_h), 32'd4);
    check("s3_d_pix", 32'(s_pix), 32'd0);
    repeat (40) tick(1, 0);

    // run dropped mid-frame
    reset_dut();
    run = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1, 0);
      if (s_en && s_v == 2'd1 && s_h == 3'd2) begin found = 1; break; end
    end
    check("s4_drop_point_seen", 32'(found), 32'd1);
    run = 1'b0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1, 0);
      if (s_en && s_v == 2'd3 && s_h == 3'd5) begin found = 1; break; end
    end
    check("s4_frame_completed", 32'(found), 32'd1);
    cnt = 0;
    repeat (6) begin
      tick(1, 0);
      if (s_en) cnt++;
    end
    check("s4_idle_beats", 32'(cnt), 32'd0);
    run = 1'b1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1, 0);
      if (s_en) begin found = 1; break; end
    end
    check("s4_restart_seen", 32'(found), 32'd1);
    check("s4_restart_v", 32'(s_v), 32'd0);
    check("s4_restart_h", 32'(s_h), 32'd0);
    repeat (10) tick(1, 0);

    // reset mid-frame with hold full
    reset_dut();
    run = 1'b1;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1, 0);
      if (s_en && s_v == 2'd2 && s_h == 3'd3) begin found = 1; break; end
    end
    check("s5_point_seen", 32'(found), 32'd1);
    n_rst = 1'b0;
    in_valid = 1'b1;
    #2;
    check("s5_rst_enable", 32'(out_enable), 32'd0);
    check("s5_rst_pixel", 32'(out_pixel), 32'd0);
    check("s5_rst_vcnt", 32'(out_vcnt), 32'd0);
    check("s5_rst_hcnt", 32'(out_hcnt), 32'd0);
    check("s5_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    run = 1'b0;
    n_rst = 1'b1;
    pix_val = 8'd1;
    cnt = 0;
    repeat (5) begin
      tick(1, 0);
      if (s_en) cnt++;
    end
    check("s5_no_beats_idle", 32'(cnt), 32'd0);
    run = 1'b1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1, 0);
      if (s_en) begin found = 1; break; end
    end
    check("s5_restart_seen", 32'(found), 32'd1);
    check("s5_restart_v", 32'(s_v), 32'd0);
    check("s5_restart_h", 32'(s_h), 32'd0);
    check("s5_restart_pix", 32'(s_pix), 32'd1);

    // randomized traffic with stalls, gaps and run toggles
    reset_dut();
    run = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (i % 120 == 80) run = 1'b0;
      if (i % 120 == 110) run = 1'b1;
      pix_val = 8'($urandom_range(0, 255));
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
    end
    run = 1'b0;
    repeat (60) tick(1, 0);
    check("final_queue_depth", 32'(exp_q.size() <= 1), 32'd1);
    check("w_frames_wrapped", 32'(widx >= 2 * FH * FW_W), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
